// File: rtl/commit_trace_pkg.sv
// commit_trace_pkg: shared record type, default width and scheduler states for the commit trace path
package commit_trace_pkg;
  localparam int XLEN_DEF = 32;
  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] nextpc;
    logic [XLEN_DEF-1:0] inst;
  } trace_rec_t;
  typedef enum logic [1:0] {RUN, DRAIN, DONE} sched_state_t;
endpackage

// File: rtl/commit_trace_sched_fifo.sv
// trace_fifo_2w1r: in-order FIFO accepting up to two records per cycle and releasing one
module trace_fifo_2w1r
  import commit_trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter type T = trace_rec_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_v0,
  input  logic                     i_v1,
  input  T                         i_d0,
  input  T                         i_d1,
  input  logic                     i_pop,
  output T                         o_head,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  T r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_count;
  logic [1:0] w_n;
  T w_first;
  assign w_n = {1'b0, i_v0} + {1'b0, i_v1};
  // a lone lane1 record takes the slot lane0 would have used
  assign w_first = i_v0 ? i_d0 : i_d1;
  assign o_head = r_mem[r_rptr];
  assign o_count = r_count;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
    end else begin
      r_wptr <= r_wptr + AW'(w_n);
      r_rptr <= r_rptr + AW'(i_pop);
      r_count <= r_count + (AW+1)'(w_n) - (AW+1)'(i_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && (i_v0 || i_v1)) r_mem[r_wptr] <= w_first;
    if (!rst && i_v0 && i_v1) r_mem[r_wptr + AW'(1)] <= i_d1;
  end
endmodule

// File: rtl/commit_trace_sched.sv
// commit_trace_sched: funnels dual-lane commit records into a one-per-cycle trace sink with halt/drain.
// Define COMMIT_TRACE_CNT_EN to add a saturating 64-bit retired-record counter output.
module commit_trace_sched
  import commit_trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int XLEN = XLEN_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     lane0_valid,
  input  logic [XLEN-1:0]          lane0_pc,
  input  logic [XLEN-1:0]          lane0_nextpc,
  input  logic [XLEN-1:0]          lane0_inst,
  input  logic                     lane1_valid,
  input  logic [XLEN-1:0]          lane1_pc,
  input  logic [XLEN-1:0]          lane1_nextpc,
  input  logic [XLEN-1:0]          lane1_inst,
  output logic                     in_ready,
  input  logic                     halt_req,
  output logic                     out_valid,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_nextpc,
  output logic [XLEN-1:0]          out_inst,
  input  logic                     out_ready,
  output logic                     drain_done,
`ifdef COMMIT_TRACE_CNT_EN
  output logic [63:0]              retired_cnt,
`endif
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int CW = $clog2(DEPTH) + 1;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] nextpc;
    logic [XLEN-1:0] inst;
  } rec_t;
  sched_state_t r_state, w_state_nxt;
  logic w_push0, w_push1, w_pop;
  logic [CW-1:0] w_cnt_nxt;
  rec_t w_head;
  // two free slots guarantee a dual-lane commit always fits
  assign in_ready = !reset && r_state == RUN && fifo_count <= CW'(DEPTH - 2);
  assign out_valid = !reset && r_state != DONE && fifo_count != '0;
  assign drain_done = r_state == DONE;
  assign w_push0 = in_ready && lane0_valid;
  assign w_push1 = in_ready && lane1_valid;
  assign w_pop = out_valid && out_ready;
  assign w_cnt_nxt = fifo_count + CW'(w_push0) + CW'(w_push1) - CW'(w_pop);
  assign out_pc = w_head.pc;
  assign out_nextpc = w_head.nextpc;
  assign out_inst = w_head.inst;
  trace_fifo_2w1r #(.DEPTH(DEPTH), .T(rec_t)) u_fifo (
    .clk    (clock),
    .rst    (reset),
    .i_v0   (w_push0),
    .i_v1   (w_push1),
    .i_d0   ('{pc: lane0_pc, nextpc: lane0_nextpc, inst: lane0_inst}),
    .i_d1   ('{pc: lane1_pc, nextpc: lane1_nextpc, inst: lane1_inst}),
    .i_pop  (w_pop),
    .o_head (w_head),
    .o_count(fifo_count)
  );
  always_comb begin
    w_state_nxt = (r_state == RUN && halt_req) ? DRAIN :
                  (r_state == DRAIN && w_cnt_nxt == '0) ? DONE : r_state;
  end
  always_ff @(posedge clock) begin
    if (reset) r_state <= RUN;
    else r_state <= w_state_nxt;
  end
`ifdef COMMIT_TRACE_CNT_EN
  always_ff @(posedge clock) begin
    if (reset) retired_cnt <= '0;
    else if (w_pop && !(&retired_cnt)) retired_cnt <= retired_cnt + 64'd1;
  end
`endif
endmodule

// File: tb/tb_commit_trace_sched.sv
// tb_commit_trace_sched: directed, hand-computed checks of the commit trace scheduler
module tb_commit_trace_sched;
  logic clock = 1'b0;
  logic reset;
  logic lane0_valid, lane1_valid, halt_req, out_ready;
  logic [31:0] lane0_pc, lane0_nextpc, lane0_inst;
  logic [31:0] lane1_pc, lane1_nextpc, lane1_inst;
  logic in_ready, out_valid, drain_done;
  logic [31:0] out_pc, out_nextpc, out_inst;
  logic [3:0] fifo_count;
`ifdef COMMIT_TRACE_CNT_EN
  logic [63:0] retired_cnt;
`endif
  int n_chk = 0;
  int n_fail = 0;

  commit_trace_sched #(.DEPTH(8), .XLEN(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .lane0_valid (lane0_valid),
    .lane0_pc    (lane0_pc),
    .lane0_nextpc(lane0_nextpc),
    .lane0_inst  (lane0_inst),
    .lane1_valid (lane1_valid),
    .lane1_pc    (lane1_pc),
    .lane1_nextpc(lane1_nextpc),
    .lane1_inst  (lane1_inst),
    .in_ready    (in_ready),
    .halt_req    (halt_req),
    .out_valid   (out_valid),
    .out_pc      (out_pc),
    .out_nextpc  (out_nextpc),
    .out_inst    (out_inst),
    .out_ready   (out_ready),
    .drain_done  (drain_done),
`ifdef COMMIT_TRACE_CNT_EN
    .retired_cnt (retired_cnt),
`endif
    .fifo_count  (fifo_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    chk("count_le_depth", {63'd0, fifo_count <= 4'd8}, 64'd1);
  endtask

  task automatic set_l0(input logic v, input logic [31:0] pc);
    lane0_valid = v; lane0_pc = pc; lane0_nextpc = pc + 32'd4; lane0_inst = pc ^ 32'h13;
  endtask

  task automatic set_l1(input logic v, input logic [31:0] pc);
    lane1_valid = v; lane1_pc = pc; lane1_nextpc = pc + 32'd4; lane1_inst = pc ^ 32'h13;
  endtask

  initial begin
    reset = 1'b1; halt_req = 1'b0; out_ready = 1'b0;
    set_l0(1'b0, 32'd0); set_l1(1'b0, 32'd0);
    tick(); tick();
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_count", {60'd0, fifo_count}, 64'd0);
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("post_rst_drain_done", {63'd0, drain_done}, 64'd0);
`ifdef COMMIT_TRACE_CNT_EN
    chk("post_rst_cnt", retired_cnt, 64'd0);
`endif
    // single lane, latency one
    out_ready = 1'b1;
    lane0_valid = 1'b1; lane0_pc = 32'h80000000; lane0_nextpc = 32'h80000004; lane0_inst = 32'h00000413;
    tick();
    lane0_valid = 1'b0;
    chk("single_valid", {63'd0, out_valid}, 64'd1);
    chk("single_pc", {32'd0, out_pc}, 64'h80000000);
    chk("single_nextpc", {32'd0, out_nextpc}, 64'h80000004);
    chk("single_inst", {32'd0, out_inst}, 64'h00000413);
    chk("single_count", {60'd0, fifo_count}, 64'd1);
    tick();
    chk("single_count_after", {60'd0, fifo_count}, 64'd0);
    chk("single_valid_after", {63'd0, out_valid}, 64'd0);
    // dual lane ordering, then lane1-only compaction
    set_l0(1'b1, 32'h100); set_l1(1'b1, 32'h104);
    tick();
    set_l0(1'b0, 32'h0); set_l1(1'b0, 32'h0);
    chk("dual_pc0", {32'd0, out_pc}, 64'h100);
    chk("dual_count", {60'd0, fifo_count}, 64'd2);
    tick();
    chk("dual_pc1", {32'd0, out_pc}, 64'h104);
    chk("dual_nextpc1", {32'd0, out_nextpc}, 64'h108);
    tick();
    chk("dual_empty", {60'd0, fifo_count}, 64'd0);
    set_l1(1'b1, 32'h200);
    tick();
    set_l1(1'b0, 32'h0);
    chk("l1only_count", {60'd0, fifo_count}, 64'd1);
    chk("l1only_pc", {32'd0, out_pc}, 64'h200);
    tick();
    chk("l1only_empty", {60'd0, fifo_count}, 64'd0);
    // backpressure: producer holds its pair once in_ready drops
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_l0(1'b1, 32'h1000 + 32'(8 * (i < 3 ? i : 3)));
      set_l1(1'b1, 32'h1004 + 32'(8 * (i < 3 ? i : 3)));
      tick();
      chk("bp_count", {60'd0, fifo_count}, 64'((2 * (i + 1)) < 8 ? 2 * (i + 1) : 8));
      chk("bp_in_ready", {63'd0, in_ready}, {63'd0, i < 3});
    end
    set_l0(1'b0, 32'h0); set_l1(1'b0, 32'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("bp_out_pc", {32'd0, out_pc}, 64'h1000 + 64'(4 * i));
      chk("bp_in_ready_drain", {63'd0, in_ready}, {63'd0, i >= 2});
      tick();
    end
    chk("bp_empty", {60'd0, fifo_count}, 64'd0);
    // drain: four buffered plus one accepted alongside the halt pulse
    out_ready = 1'b0;
    set_l0(1'b1, 32'h2000); set_l1(1'b1, 32'h2004);
    tick();
    set_l0(1'b1, 32'h2008); set_l1(1'b1, 32'h200c);
    tick();
    set_l0(1'b1, 32'h2010); set_l1(1'b0, 32'h0);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    set_l0(1'b0, 32'h0);
    chk("drain_count", {60'd0, fifo_count}, 64'd5);
    chk("drain_in_ready", {63'd0, in_ready}, 64'd0);
    chk("drain_done_early", {63'd0, drain_done}, 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("drain_pc", {32'd0, out_pc}, 64'h2000 + 64'(4 * i));
      chk("drain_not_done", {63'd0, drain_done}, 64'd0);
      tick();
    end
    chk("drain_empty", {60'd0, fifo_count}, 64'd0);
    chk("drain_done", {63'd0, drain_done}, 64'd1);
    chk("drain_out_valid", {63'd0, out_valid}, 64'd0);
    halt_req = 1'b1; set_l0(1'b1, 32'h3000);
    tick();
    halt_req = 1'b0; set_l0(1'b0, 32'h0);
    tick();
    chk("done_hold", {63'd0, drain_done}, 64'd1);
    chk("done_in_ready", {63'd0, in_ready}, 64'd0);
    chk("done_count", {60'd0, fifo_count}, 64'd0);
    // reset mid-run discards buffered records
    reset = 1'b1; tick(); reset = 1'b0; tick();
    chk("rerun_in_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b0;
    set_l0(1'b1, 32'h4000); set_l1(1'b1, 32'h4004);
    tick();
    set_l1(1'b0, 32'h0); set_l0(1'b1, 32'h4008);
    tick();
    set_l0(1'b0, 32'h0);
    chk("mid_count", {60'd0, fifo_count}, 64'd3);
    reset = 1'b1;
    tick();
    chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    reset = 1'b0;
    tick();
    chk("mid_count0", {60'd0, fifo_count}, 64'd0);
    chk("mid_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_in_ready", {63'd0, in_ready}, 64'd1);
    chk("mid_drain_done", {63'd0, drain_done}, 64'd0);
`ifdef COMMIT_TRACE_CNT_EN
    chk("mid_cnt", retired_cnt, 64'd0);
`endif
    // halt with an empty FIFO: done two edges after the pulse
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("empty_halt_d1", {63'd0, drain_done}, 64'd0);
    chk("empty_halt_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    chk("empty_halt_d2", {63'd0, drain_done}, 64'd1);
    // ten records popped, then a stalled head
    reset = 1'b1; tick(); reset = 1'b0; tick();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_l0(1'b1, 32'h5000 + 32'(8 * i)); set_l1(1'b1, 32'h5004 + 32'(8 * i));
      tick();
      chk("cnt_fill", {60'd0, fifo_count}, 64'(i + 2));
    end
    set_l0(1'b0, 32'h0); set_l1(1'b0, 32'h0);
    for (int i = 0; i < 8; i++) tick();
    chk("cnt_empty", {60'd0, fifo_count}, 64'd0);
`ifdef COMMIT_TRACE_CNT_EN
    chk("cnt_ten", retired_cnt, 64'd10);
`endif
    out_ready = 1'b0;
    set_l0(1'b1, 32'h6000);
    tick();
    set_l0(1'b0, 32'h0);
    tick(); tick();
    chk("stall_count", {60'd0, fifo_count}, 64'd1);
    chk("stall_pc", {32'd0, out_pc}, 64'h6000);
`ifdef COMMIT_TRACE_CNT_EN
    chk("stall_cnt", retired_cnt, 64'd10);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
